mode_select_ctrl: RTL
=====================

Name: mode_select_ctrl

Overview:
- Parametrised button-conditioning and mode-control block for the stopwatch/clock designs. Generalises the single-button adjust-state logic.
- Provides NUM_BTN synchronised, debounced buttons with press, long-press and auto-repeat pulses.
- Provides an N-mode cycling FSM, a pause toggle and a blink indicator.
- Runs entirely on clk with counter-based timing, so it needs no derived clocks. Sits between the board buttons and the display/counter datapath.

Parameters:
- NUM_BTN, 2, number of buttons (min 2). btn[0] = mode advance, btn[1] = pause toggle.
- DB_CYCLES, 500000, consecutive stable cycles required to accept a level change.
- HOLD_CYCLES, 50000000, cycles held (from press) before the long-press pulse.
- REPEAT_CYCLES, 10000000, auto-repeat period after the long press.
- NUM_MODES, 3, number of modes. Mode 0 = run; modes 1..NUM_MODES-1 = adjust.
- BLINK_CYCLES, 25000000, blink half-period in cycles.
- MODE_W, max(1,$clog2(NUM_MODES)), derived width of mode.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- btn_raw, input, NUM_BTN, raw asynchronous button inputs, active-high.
- btn_level, output, NUM_BTN, debounced level.
- btn_press, output, NUM_BTN, 1-cycle pulse on debounced rising edge.
- btn_long, output, NUM_BTN, 1-cycle pulse when held HOLD_CYCLES.
- btn_rpt, output, NUM_BTN, 1-cycle auto-repeat pulses.
- mode, output, MODE_W, current mode.
- adj_active, output, 1, high when mode != 0.
- paused, output, 1, pause state.
- blink, output, 1, blink square wave, gated by adj_active.

Behaviour:
- Reset is asynchronous and active-high. All registers clear: btn_level/press/long/rpt = 0, mode = 0, paused = 0, blink = 0, and every counter = 0.
- Sync: each btn_raw passes through a 2-flop synchroniser. Only the synchronised value is used.
- Debounce (per button):
  - Counter increments while sync != btn_level and clears when they are equal.
  - When the counter reaches DB_CYCLES-1 while still differing, btn_level flips and the counter clears.
  - Glitches shorter than DB_CYCLES cycles are ignored.
  - Latency: btn_level rises DB_CYCLES+2 cycles after btn_raw first sampled high.
- Press: btn_press[i] = 1 in exactly the first cycle btn_level[i] = 1 (registered edge detect). There is no pulse on release.
- Hold counter (per button):
  - Cleared at press; counts while btn_level = 1 and saturates.
  - The press cycle is count 0.
  - btn_long pulses at count HOLD_CYCLES.
  - btn_rpt pulses at HOLD_CYCLES + n*REPEAT_CYCLES, n >= 1, for as long as the button is held.
  - Release clears the counter immediately; no further pulses are issued.
- Mode FSM:
  - btn_press[0] advances mode: m -> m+1, and NUM_MODES-1 -> 0 (wrap).
  - btn_rpt[0] and btn_long[0] do not advance the mode.
  - Mode updates the cycle after btn_press[0].
- Pause:
  - btn_press[1] toggles paused only when mode == 0.
  - In adjust modes the pulse still appears on btn_press[1], but paused is unchanged.
  - A mode change never alters paused.
- Simultaneous btn_press[0] and btn_press[1] in mode 0: both take effect. Paused toggles (mode was 0 in that cycle) and mode advances.
- Blink:
  - Free-running half-period counter toggles an internal square wave every BLINK_CYCLES.
  - blink = square & adj_active. blink is 0 in mode 0.
- Button held through reset release: btn_level restarts from 0. A press pulse therefore occurs after DB_CYCLES+2 cycles. This is intended.
- Buttons beyond index 1 only provide conditioned outputs.

Decomposition:
- Shared package mode_ctrl_pkg:
  - Mode constants: MODE_RUN = 0.
  - Button index constants: BTN_MODE = 0, BTN_PAUSE = 1.
  - Default timing constants for 100 MHz.
- Sub-module btn_conditioner: synchroniser + debounce + press/long/repeat for one button, parameterised by DB/HOLD/REPEAT. It is instantiated NUM_BTN times via generate. The top holds the mode FSM, pause register and blink logic.

Test Plan:
Bench parameters: DB=4, HOLD=16, REPEAT=8, NUM_MODES=3, BLINK=5.
- Reset: assert reset with btn_raw = 2'b11 -> all outputs 0 during reset. Release -> btn_press = 2'b11 exactly once, at cycle 6.
- Bounce: btn_raw[0] high 3 cycles, low 1, high 3, low -> no btn_level/btn_press; mode = 0. Hold high 10 cycles -> one btn_press[0]; mode = 1 the following cycle.
- Wrap: three clean presses on btn[0] -> mode 1, 2, 0. blink toggles every 5 cycles in modes 1 and 2, and stays 0 in mode 0.
- Pause gating: mode 0, press btn[1] -> paused = 1. Advance to mode 1, press btn[1] -> btn_press[1] pulses, paused stays 1. Return to mode 0, press btn[1] -> paused = 0.
- Long/repeat: hold btn[1] 45 cycles past press -> btn_long at count 16 and btn_rpt at counts 24, 32, 40. Release -> no further pulses. paused toggled only once (at press).
- Reset mid-hold: reset at hold count 20 in mode 2 -> mode = 0, paused = 0, no btn_rpt at count 24. Button still held -> fresh press at cycle 6 after release, mode = 1.

Source files
------------

// File: rtl/mode_ctrl_pkg.sv
// Shared constants for the button-conditioning / mode-control slice.
// Timing defaults assume a 100 MHz clock.
package mode_ctrl_pkg;

    localparam int MODE_RUN  = 0;
    localparam int BTN_MODE  = 0;
    localparam int BTN_PAUSE = 1;

    localparam int DEF_DB_CYCLES     = 500_000;      // 5 ms
    localparam int DEF_HOLD_CYCLES   = 50_000_000;   // 500 ms
    localparam int DEF_REPEAT_CYCLES = 10_000_000;   // 100 ms
    localparam int DEF_BLINK_CYCLES  = 25_000_000;   // 250 ms half-period

    // Counter width for values 0..value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 2) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/mode_select_ctrl_if.sv
// Board-button inputs and conditioned/mode outputs of mode_select_ctrl.
// The slave side is the controller; the master side drives the raw buttons.
interface mode_select_ctrl_if #(
    parameter int NUM_BTN = 2,
    parameter int MODE_W  = 2
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_long;
    logic [NUM_BTN-1:0] btn_rpt;
    logic [MODE_W-1:0]  mode;
    logic               adj_active;
    logic               paused;
    logic               blink;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_long, btn_rpt,
        input  mode, adj_active, paused, blink
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_long, btn_rpt,
        output mode, adj_active, paused, blink
    );

endinterface

// File: rtl/btn_conditioner.sv
// One button: 2-flop synchroniser, counter debounce, press edge,
// long-press pulse and auto-repeat pulses while held.
module btn_conditioner
    import mode_ctrl_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic long_press,
    output logic rpt
);

    localparam int DB_W   = clog2_min1(DB_CYCLES);
    localparam int HOLD_W = clog2_min1(HOLD_CYCLES + 1);
    localparam int RPT_W  = clog2_min1(REPEAT_CYCLES);

    logic [1:0]        sync;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [RPT_W-1:0]  rpt_cnt;
    logic              differ;
    logic              flip;
    logic              level_nxt;
    logic              hold_sat;
    logic              rpt_wrap;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], raw};
        end
    end

    // NOTE: every always_comb output is assigned on all paths to avoid latches.
    always_comb begin
        differ    = sync[1] ^ level;
        flip      = differ && (db_cnt == DB_W'(DB_CYCLES - 1));
        level_nxt = level ^ flip;
        hold_sat  = (hold_cnt == HOLD_W'(HOLD_CYCLES));
        rpt_wrap  = (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else begin
            level <= level_nxt;
            if (!differ || flip) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // The press cycle is hold count 0; repeats are timed by rpt_cnt once hold_cnt saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt   <= '0;
            rpt_cnt    <= '0;
            press      <= 1'b0;
            long_press <= 1'b0;
            rpt        <= 1'b0;
        end else begin
            press      <= level_nxt & ~level;
            long_press <= 1'b0;
            rpt        <= 1'b0;
            if (!level || !level_nxt) begin
                hold_cnt <= '0;
                rpt_cnt  <= '0;
            end else if (!hold_sat) begin
                hold_cnt   <= hold_cnt + 1'b1;
                long_press <= (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
            end else begin
                rpt_cnt <= rpt_wrap ? '0 : rpt_cnt + 1'b1;
                rpt     <= rpt_wrap;
            end
        end
    end

endmodule

// File: rtl/mode_select_ctrl.sv
// Button conditioning plus mode-cycling FSM, run-mode pause toggle and
// adjust-mode blink indicator for the stopwatch/clock datapath.
module mode_select_ctrl
    import mode_ctrl_pkg::*;
#(
    parameter int NUM_BTN       = 2,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int NUM_MODES     = 3,
    parameter int BLINK_CYCLES  = DEF_BLINK_CYCLES
) (
    input logic               clk,
    input logic               reset,
    mode_select_ctrl_if.slave bus
);

    localparam int MODE_W  = clog2_min1(NUM_MODES);
    localparam int BLINK_W = clog2_min1(BLINK_CYCLES);
    localparam logic [MODE_W-1:0] RUN_CODE  = MODE_W'(MODE_RUN);
    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] long_press;
    logic [NUM_BTN-1:0] rpt;

    logic [MODE_W-1:0]  mode;
    logic [MODE_W-1:0]  mode_nxt;
    logic               paused;
    logic               paused_nxt;
    logic               in_run;
    logic               adj_active;
    logic [BLINK_W-1:0] blink_cnt;
    logic               square;
    logic               blink;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_conditioner #(
                .DB_CYCLES     (DB_CYCLES),
                .HOLD_CYCLES   (HOLD_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES)
            ) u_cond (
                .clk        (clk),
                .reset      (reset),
                .raw        (bus.btn_raw[gi]),
                .level      (level[gi]),
                .press      (press[gi]),
                .long_press (long_press[gi]),
                .rpt        (rpt[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode   <= RUN_CODE;
            paused <= 1'b0;
        end else begin
            mode   <= mode_nxt;
            paused <= paused_nxt;
        end
    end

    // Only the press edge steers the FSM; long/repeat pulses are for the datapath.
    always_comb begin
        mode_nxt   = mode;
        paused_nxt = paused;
        if (press[BTN_PAUSE] && in_run) begin
            paused_nxt = !paused;
        end
        if (press[BTN_MODE]) begin
            mode_nxt = (mode == LAST_MODE) ? RUN_CODE : mode + 1'b1;
        end
    end

    always_comb begin
        in_run     = (mode == RUN_CODE);
        adj_active = !in_run;
        blink      = square & adj_active;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            square    <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            square    <= ~square;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign bus.btn_level  = level;
    assign bus.btn_press  = press;
    assign bus.btn_long   = long_press;
    assign bus.btn_rpt    = rpt;
    assign bus.mode       = mode;
    assign bus.adj_active = adj_active;
    assign bus.paused     = paused;
    assign bus.blink      = blink;

endmodule
